// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected layer sequencer.
// Defaults track the Q5.11, 4-lane MAC datapath.
package fc_pkg;

  localparam int FC_SIZE      = 16;
  localparam int FC_PRECISION = 11;
  localparam int FC_LANES     = 4;
  localparam int FC_CNT_W     = 12;
  localparam int FC_ADDR_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    CLEAR,
    ACC,
    CAPT,
    WRITE
  } fc_state_t;

  // Full mask except on the last chunk of a ragged input vector.
  function automatic logic [31:0] lane_mask_f(input logic last, input logic [31:0] rem);
    if (!last || rem == 32'd0) lane_mask_f = '1;
    else                       lane_mask_f = (32'd1 << rem) - 32'd1;
  endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Chunk counter, running weight pointer and lane mask for the accumulate phase.
// Addresses lead the enable by one chunk to cover the 1-cycle memory latency.
module fc_addr_gen
  import fc_pkg::*;
#(
  parameter int INPUT_SZ = FC_LANES,
  parameter int CNT_W    = FC_CNT_W,
  parameter int ADDR_W   = FC_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  input  logic                in_clear,
  input  logic                in_acc,
  input  logic [CNT_W-1:0]    n_chunks,
  input  logic [CNT_W-1:0]    rem,
  output logic [ADDR_W-1:0]   w_ptr,
  output logic [ADDR_W-1:0]   x_addr,
  output logic                last,
  output logic [INPUT_SZ-1:0] lane_mask
);

  logic [CNT_W-1:0] k;

  assign last = (k == n_chunks - CNT_W'(1));

  // w_ptr is never rewound between neurons: it already sits on the next neuron's base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      w_ptr <= '0;
    end else if (restart) begin
      k     <= '0;
      w_ptr <= '0;
    end else if (in_clear) begin
      k     <= '0;
      w_ptr <= w_ptr + ADDR_W'(1);
    end else if (in_acc && !last) begin
      k     <= k + CNT_W'(1);
      w_ptr <= w_ptr + ADDR_W'(1);
    end
  end

  assign x_addr    = in_acc ? ADDR_W'(k) + ADDR_W'(1) : '0;
  assign lane_mask = in_acc ? INPUT_SZ'(lane_mask_f(last, 32'(rem))) : '0;

endmodule

// File: rtl/fc_sequencer.sv
// Per-neuron sequencer for one fully-connected layer: bias clear, chunked
// accumulate, then a valid/ready hand-off of each neuron result.
module fc_sequencer
  import fc_pkg::*;
#(
  parameter int SIZE     = FC_SIZE,
  parameter int INPUT_SZ = FC_LANES,
  parameter int CNT_W    = FC_CNT_W,
  parameter int ADDR_W   = FC_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    in_count,
  input  logic [CNT_W-1:0]    out_count,
  output logic [ADDR_W-1:0]   b_addr,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [ADDR_W-1:0]   x_addr,
  output logic [INPUT_SZ-1:0] lane_mask,
  output logic                alu_clear,
  output logic                alu_enable,
  input  logic [SIZE-1:0]     alu_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE-1:0]     out_data,
  output logic [CNT_W-1:0]    out_addr,
  output logic                busy,
  output logic                done
);

  fc_state_t        state, state_nxt;
  logic             done_nxt;
  logic             accept;
  logic             last_chunk;
  logic             last_neuron;
  logic [CNT_W-1:0] neuron;
  logic [CNT_W-1:0] n_chunks;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] out_cnt;

  assign accept      = (state == IDLE) && start && !abort &&
                       (in_count != '0) && (out_count != '0);
  assign last_neuron = (neuron == out_cnt - CNT_W'(1));

  fc_addr_gen #(
    .INPUT_SZ(INPUT_SZ),
    .CNT_W   (CNT_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .restart  (accept || abort),
    .in_clear (state == CLEAR),
    .in_acc   (state == ACC),
    .n_chunks (n_chunks),
    .rem      (rem),
    .w_ptr    (w_addr),
    .x_addr   (x_addr),
    .last     (last_chunk),
    .lane_mask(lane_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // abort overrides everything, including a transfer or a start in the same cycle
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept)     state_nxt = BIAS;
          else if (start) done_nxt  = 1'b1;
        end
        BIAS:  state_nxt = CLEAR;
        CLEAR: state_nxt = ACC;
        ACC:   if (last_chunk) state_nxt = CAPT;
        CAPT:  state_nxt = WRITE;
        WRITE: begin
          if (out_ready) begin
            if (last_neuron) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = BIAS;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Layer parameters, neuron index and the registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neuron    <= '0;
      n_chunks  <= '0;
      rem       <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (abort) begin
      neuron    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        neuron   <= '0;
        n_chunks <= CNT_W'(in_count / INPUT_SZ) + CNT_W'((in_count % INPUT_SZ) != 0);
        rem      <= CNT_W'(in_count % INPUT_SZ);
        out_cnt  <= out_count;
      end
      if (state == CAPT) begin
        out_data  <= alu_value;
        out_addr  <= neuron;
        out_valid <= 1'b1;
      end
      if (state == WRITE && out_ready) begin
        out_valid <= 1'b0;
        if (!last_neuron) neuron <= neuron + CNT_W'(1);
      end
    end
  end

  assign b_addr     = ADDR_W'(neuron);
  assign alu_clear  = (state == CLEAR);
  assign alu_enable = (state == ACC);
  assign busy       = (state != IDLE);

endmodule
